// File: rtl/sr_icache_if.sv
// CPU fetch + backing-memory read bundle for the icache controller.
// slave: the cache controller side; master: CPU/memory environment side.
interface sr_icache_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic        cpu_drdy;
  logic [31:0] cpu_data;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;

  modport slave (
    input  cpu_req, cpu_addr, flush,
    input  mem_ack, mem_rdata,
    output cpu_drdy, cpu_data,
    output mem_req, mem_addr, busy
  );

  modport master (
    output cpu_req, cpu_addr, flush,
    output mem_ack, mem_rdata,
    input  cpu_drdy, cpu_data,
    input  mem_req, mem_addr, busy
  );
endinterface

// File: rtl/sr_icache_ctrl.sv
// Direct-mapped instruction cache controller, word-serial line refill.
// Ports: clk, rst_n (async low), bus (sr_icache_if.slave: cpu/mem/flush/busy).
module sr_icache_ctrl #(
  parameter int INDEX_W = 4,
  parameter int OFFS_W  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  sr_icache_if.slave  bus
);
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << (INDEX_W + OFFS_W);
  localparam int TAG_W = 30 - INDEX_W - OFFS_W;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    RESP
  } state_e;

  state_e state_q, state_d;

  logic [OFFS_W-1:0]  a_off;
  logic [INDEX_W-1:0] a_idx;
  logic [TAG_W-1:0]   a_tag;

  logic [31:0]      data_mem [WORDS];
  logic [TAG_W-1:0] tag_mem  [LINES];

  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   r_tag_q;
  logic [INDEX_W-1:0] r_idx_q;
  logic [OFFS_W-1:0]  r_off_q;
  logic [OFFS_W-1:0]  cnt_q;
  logic               pend_q;
  logic               drdy_q;
  logic [31:0]        data_q;

  logic lookup, hit, miss;
  logic in_refill, ack_w, last_w, fill_done;
  logic unused_ok;

  assign a_off = bus.cpu_addr[OFFS_W+1:2];
  assign a_idx = bus.cpu_addr[OFFS_W+2 +: INDEX_W];
  assign a_tag = bus.cpu_addr[31 -: TAG_W];
  assign unused_ok = ^bus.cpu_addr[1:0];

  // The drdy cycle is a dead cycle: the CPU has not yet
  // presented its next request, so no lookup is made.
  assign lookup = (state_q == IDLE) && bus.cpu_req && !drdy_q;
  assign hit    = lookup && valid_q[a_idx]
                  && (tag_mem[a_idx] == a_tag);
  assign miss   = lookup && !hit;

  assign in_refill = (state_q == REFILL);
  assign ack_w     = in_refill && bus.mem_ack;
  assign last_w    = (cnt_q == '1);
  assign fill_done = ack_w && last_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss)      state_d = REFILL;
      REFILL:  if (fill_done) state_d = RESP;
      RESP:                   state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    bus.busy     = (state_q != IDLE);
    if (in_refill) begin
      bus.mem_req  = 1'b1;
      bus.mem_addr = {r_tag_q, r_idx_q, cnt_q, 2'b00};
    end
  end

  assign bus.cpu_drdy = drdy_q;
  assign bus.cpu_data = data_q;

  // A flush seen in REFILL is held until RESP, so the line
  // being filled is still returned before everything drops.
  always_comb begin
    valid_d = valid_q;
    if (fill_done)
      valid_d[r_idx_q] = 1'b1;
    if (state_q == IDLE && bus.flush)
      valid_d = '0;
    if (state_q == RESP && (pend_q || bus.flush))
      valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      r_tag_q <= '0;
      r_idx_q <= '0;
      r_off_q <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      drdy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      drdy_q  <= 1'b0;
      pend_q  <= in_refill ? (pend_q | bus.flush) : 1'b0;
      if (hit) begin
        data_q <= data_mem[{a_idx, a_off}];
        drdy_q <= 1'b1;
      end
      if (state_q == RESP) begin
        data_q <= data_mem[{r_idx_q, r_off_q}];
        drdy_q <= 1'b1;
      end
      if (miss) begin
        r_tag_q <= a_tag;
        r_idx_q <= a_idx;
        r_off_q <= a_off;
        cnt_q   <= '0;
      end else if (ack_w && !last_w) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Arrays carry no reset; valid_q alone qualifies them.
  always_ff @(posedge clk) begin
    if (ack_w)
      data_mem[{r_idx_q, cnt_q}] <= bus.mem_rdata;
    if (fill_done)
      tag_mem[r_idx_q] <= r_tag_q;
  end
endmodule

// File: tb/tb_sr_icache_ctrl.sv
// Self-checking bench for sr_icache_ctrl (default parameters).
// Reference: line-presence table plus a fixed memory content function.
module tb_sr_icache_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  sr_icache_if bus();

  sr_icache_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  int ack_delay = 0;
  int wcnt = 0;
  logic [31:0] mem_log[$];
  int unstable = 0;
  int drdy_dbl = 0;
  int req_err = 0;
  logic prev_req = 1'b0;
  logic prev_ack = 1'b0;
  logic prev_drdy = 1'b0;
  logic [31:0] prev_addr = '0;

  logic        mv [16];
  logic [31:0] mt [16];

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  // Memory responder and protocol monitors.
  always @(negedge clk) begin
    if (bus.mem_req) begin
      if (prev_req && !prev_ack && bus.mem_addr !== prev_addr)
        unstable++;
      if (wcnt == ack_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mw(bus.mem_addr);
        mem_log.push_back(bus.mem_addr);
        wcnt = 0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        wcnt++;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      wcnt = 0;
    end
    prev_req  = bus.mem_req;
    prev_ack  = bus.mem_ack;
    prev_addr = bus.mem_addr;
    if (bus.cpu_drdy && prev_drdy) drdy_dbl++;
    if (bus.mem_req && !bus.busy) req_err++;
    prev_drdy = bus.cpu_drdy;
  end

  task automatic do_fetch(input logic [31:0] a, input int dly,
                          input int fl_at);
    int idx, lat, exp_lat, fl;
    logic [31:0] tg, base, d;
    logic hit, ok;
    idx  = int'((a >> 4) & 32'hF);
    tg   = a >> 8;
    base = a & 32'hFFFF_FFF0;
    hit  = mv[idx] && (mt[idx] == tg);
    exp_lat = hit ? 1 : 4 * (dly + 1) + 2;
    fl = hit ? 0 : fl_at;
    ack_delay = dly;
    mem_log.delete();
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    lat = 0;
    ok  = 1'b0;
    d   = '0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      lat++;
      bus.flush = (fl > 0 && lat == fl);
      if (bus.cpu_drdy) begin
        ok = 1'b1;
        d  = bus.cpu_data;
      end
    end
    bus.flush = 1'b0;
    @(negedge clk);
    bus.cpu_req = 1'b0;
    chk("drdy_seen", {31'd0, ok}, 32'd1);
    chk("data", d, mw(a));
    chk("latency", lat, exp_lat);
    chk("mem_words", mem_log.size(), hit ? 0 : 4);
    if (!hit && mem_log.size() == 4)
      for (int k = 0; k < 4; k++)
        chk("mem_addr", mem_log[k], base + 32'(4 * k));
    if (!hit) begin
      mv[idx] = 1'b1;
      mt[idx] = tg;
    end
    if (fl > 0) model_clear();
  endtask

  task automatic idle_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    model_clear();
  endtask

  initial begin
    int n;
    logic [31:0] ra;
    bus.cpu_req  = 1'b0;
    bus.cpu_addr = '0;
    bus.flush    = 1'b0;
    model_clear();
    for (int i = 0; i < 16; i++) mt[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_drdy", {31'd0, bus.cpu_drdy}, 32'd0);
    chk("rst_data", bus.cpu_data, 32'd0);
    chk("rst_mreq", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_maddr", bus.mem_addr, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_fetch(32'h10, 0, 0);
    do_fetch(32'h18, 0, 0);
    do_fetch(32'h110, 0, 0);
    do_fetch(32'h10, 0, 0);
    do_fetch(32'h30, 3, 0);
    do_fetch(32'h20, 0, 2);
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    do_fetch(32'h20, 0, 0);

    do_fetch(32'h24, 0, 0);
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h28;
    @(posedge clk); #1;
    chk("b2b_drdy1", {31'd0, bus.cpu_drdy}, 32'd1);
    chk("b2b_data1", bus.cpu_data, mw(32'h28));
    @(posedge clk); #1;
    chk("b2b_gap", {31'd0, bus.cpu_drdy}, 32'd0);
    @(posedge clk); #1;
    chk("b2b_drdy2", {31'd0, bus.cpu_drdy}, 32'd1);
    @(negedge clk);
    bus.cpu_req = 1'b0;

    idle_flush();
    do_fetch(32'h24, 1, 0);

    model_clear();
    idle_flush();
    ack_delay = 0;
    mem_log.delete();
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h20;
    n = 0;
    while (mem_log.size() < 2 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_two_acks", mem_log.size(), 2);
    rst_n = 1'b0;
    bus.cpu_req = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_mreq", {31'd0, bus.mem_req}, 32'd0);
    chk("mid_rst_maddr", bus.mem_addr, 32'd0);
    chk("mid_rst_data", bus.cpu_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_drdy", {31'd0, bus.cpu_drdy}, 32'd0);
    end
    do_fetch(32'h20, 0, 0);

    for (int i = 0; i < 60; i++) begin
      ra = (32'($urandom_range(0, 2)) << 8)
         | (32'($urandom_range(0, 3)) << 4)
         | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 7) == 0) idle_flush();
      do_fetch(ra, int'($urandom_range(0, 2)),
               ($urandom_range(0, 5) == 0) ? 3 : 0);
    end

    repeat (2) @(negedge clk);
    chk("addr_stable", unstable, 0);
    chk("drdy_double", drdy_dbl, 0);
    chk("mreq_outside", req_err, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sr_icache_ctrl.md
SR_ICACHE_CTRL -- requirements
Module: sr_icache_ctrl

Interface
REQ-001 Parameter INDEX_W, default 4, number of index bits (2**INDEX_W lines, direct-mapped).
REQ-002 Parameter OFFS_W, default 2, word-offset bits (2**OFFS_W 32-bit words per line).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cpu_req  input  1  fetch request; held high with stable cpu_addr until cpu_drdy.
REQ-006 cpu_addr  input  32  byte address of the fetch; bits [1:0] ignored.
REQ-007 cpu_drdy  output  1  one-cycle pulse: cpu_data valid for the current request.
REQ-008 cpu_data  output  32  fetched instruction word.
REQ-009 flush  input  1  single-cycle pulse: invalidate all lines.
REQ-010 mem_req  output  1  backing-memory word read request.
REQ-011 mem_addr  output  32  word-aligned backing-memory byte address.
REQ-012 mem_ack  input  1  read complete; mem_rdata valid in the same cycle.
REQ-013 mem_rdata  input  32  backing-memory read data.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Internal storage: data array 2**(INDEX_W+OFFS_W) x 32, tag array 2**INDEX_W x (30-INDEX_W-OFFS_W), valid bit per line.
REQ-016 Address split: offset = cpu_addr[OFFS_W+1:2], index = next INDEX_W bits, tag = remaining upper bits.
REQ-017 FSM states: IDLE, REFILL, RESP; encoding free.
REQ-018 IDLE, cpu_req=1, valid[index]=1 and tag match (hit): cpu_data <= addressed word, cpu_drdy=1 next cycle, stay IDLE.
REQ-019 Hit latency: exactly 1 cycle from request sampled to cpu_drdy; back-to-back hits give one cpu_drdy every second cycle (request must be re-sampled after drdy cycle).
REQ-020 In the cycle cpu_drdy=1, the controller ignores cpu_req (no new lookup).
REQ-021 IDLE, cpu_req=1, miss: latch line base address, word counter <= 0, go REFILL.
REQ-022 REFILL: mem_req=1, mem_addr = line base + 4*counter; address stable while mem_req high and mem_ack low.
REQ-023 On mem_ack: write mem_rdata into data array at {index, counter}; counter increments; mem_req may stay high for the next word without a gap.
REQ-024 Refill order is always word 0 to word 2**OFFS_W-1 (no critical-word-first).
REQ-025 On ack of last word: write tag, set valid[index], go RESP; mem_req=0 in the following cycle.
REQ-026 RESP: cpu_data <= requested word from array, cpu_drdy=1 next cycle, return to IDLE.
REQ-027 Miss latency with mem_ack tied high: 2**OFFS_W + 2 cycles from request sampled to cpu_drdy (6 with defaults).
REQ-028 mem_req is never high outside REFILL.
REQ-029 flush in IDLE with no lookup in progress: all valid bits cleared at that edge.
REQ-030 flush coincident with an IDLE lookup: lookup completes on current array contents, clear applied the same edge (next request misses).
REQ-031 flush during REFILL or RESP: latched pending; the line being refilled still becomes valid and is returned; all valids cleared on entering IDLE.
REQ-032 Counter wraps to 0 only via reset or new miss; no other counter wrap.
REQ-033 cpu_drdy is never high for two consecutive cycles.

Reset
REQ-034 rst_n=0 asynchronously: state IDLE, all valid bits 0, pending flush 0, counter 0, cpu_drdy 0, cpu_data 0, mem_req 0, mem_addr 0, busy 0.
REQ-035 Reset asserted mid-REFILL aborts the refill; partially written line stays invalid; no cpu_drdy issued for the aborted request.
REQ-036 Data and tag array contents need not be reset.

Verification
REQ-037 Cold miss: after reset, cpu_req with addr 0x0000_0010, mem_ack=1 always, mem_rdata=addr-derived -> mem_addr 0x10,0x14,0x18,0x1C, cpu_drdy on cycle 6 with data of 0x10.
REQ-038 Hit: then cpu_req addr 0x0000_0018 -> cpu_drdy after 1 cycle, data of 0x18, mem_req stays 0.
REQ-039 Conflict: addr 0x0000_0110 (same index, different tag) -> miss, refill 0x110..0x11C; subsequent 0x10 misses again.
REQ-040 Stalled memory: mem_ack low for 3 cycles per word -> mem_addr held stable while waiting, miss latency 18 cycles, correct data.
REQ-041 Flush mid-refill: flush pulse during REFILL of 0x20 -> 0x20 returned correctly, busy drops, next request to 0x20 misses.
REQ-042 Reset mid-refill: rst_n low after 2 acks, then release, request 0x20 -> full 4-word refill, no stale hit, no spurious cpu_drdy.
